// File: rtl/fp_status_monitor.sv
`default_nettype none
// ============================================================================
// Module   : fp_status_monitor
// Purpose  : Run-time checker for an FP multiplier's status/result port.
//            It delays the operands so that they line up with the result.
//            For every valid result it checks that the status bits are legal
//            and that they agree with the result and operands. It records
//            sticky per-check flags, a saturating violation counter and the
//            code of the first error.
// Options  : FP_MON_CAPTURE_EN - when defined, cap_a/cap_b/cap_z/cap_status
//            snapshot the operands, result and status of the first bad
//            result. When it is not defined, these outputs are tied to 0.
// Ports    : clk            - clock, rising edge
//            rst            - asynchronous reset, active low
//            valid_in       - a/b carry a new operation this cycle
//            a, b           - multiplier operands (DW bits)
//            z              - multiplier result, LATENCY cycles after valid_in
//            status         - {rsv7,rsv6,inexact,huge,tiny,nan,inf,zero}
//            clear          - synchronous clear of flags/count/first-error
//            err_flags      - sticky flag per check (bit index = check number)
//            err_any        - OR of err_flags
//            err_count      - results with >=1 violation, saturating
//            first_err_code - lowest failing check of the first bad result
//            first_err_vld  - first_err_code/cap_* hold a captured value
//            cap_a/b/z      - operands/result of the first bad result
//            cap_status     - status of the first bad result
// Revision : 1.0 - initial release
// ============================================================================
module fp_status_monitor #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16,
  parameter int DW      = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  input  logic [DW-1:0]    z,
  input  logic [7:0]       status,
  input  logic             clear,
  output logic [13:0]      err_flags,
  output logic             err_any,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       first_err_code,
  output logic             first_err_vld,
  output logic [DW-1:0]    cap_a,
  output logic [DW-1:0]    cap_b,
  output logic [DW-1:0]    cap_z,
  output logic [7:0]       cap_status
);

  localparam logic [EXP_W-1:0] C_EXP_ONES    = '1;
  localparam logic [EXP_W-1:0] C_EXP_ONES_M1 = C_EXP_ONES - 1'b1;
  localparam logic [EXP_W-1:0] C_EXP_ONE     = EXP_W'(1);
  localparam logic [MAN_W-1:0] C_MAN_ONES    = '1;
  localparam logic [CNT_W-1:0] C_CNT_MAX     = '1;

  // --------------------------------------------------------------------------
  // Alignment delay lines (the clear input does not affect them)
  // --------------------------------------------------------------------------
  logic [LATENCY-1:0]         valid_pipe_q, valid_pipe_d;
  logic [LATENCY-1:0][DW-1:0] a_pipe_q, a_pipe_d;
  logic [LATENCY-1:0][DW-1:0] b_pipe_q, b_pipe_d;

  always_comb begin
    valid_pipe_d = valid_pipe_q;
    a_pipe_d     = a_pipe_q;
    b_pipe_d     = b_pipe_q;
    valid_pipe_d[0] = valid_in;
    a_pipe_d[0]     = a;
    b_pipe_d[0]     = b;
    for (int i = 1; i < LATENCY; i++) begin
      valid_pipe_d[i] = valid_pipe_q[i-1];
      a_pipe_d[i]     = a_pipe_q[i-1];
      b_pipe_d[i]     = b_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_pipe_q <= '0;
      a_pipe_q     <= '0;
      b_pipe_q     <= '0;
    end else begin
      valid_pipe_q <= valid_pipe_d;
      a_pipe_q     <= a_pipe_d;
      b_pipe_q     <= b_pipe_d;
    end
  end

  logic             res_vld;
  logic [DW-1:0]    a_al, b_al;
  assign res_vld = valid_pipe_q[LATENCY-1];
  assign a_al    = a_pipe_q[LATENCY-1];
  assign b_al    = b_pipe_q[LATENCY-1];

  // --------------------------------------------------------------------------
  // Checks on the aligned sample
  // --------------------------------------------------------------------------
  logic             st_zero, st_inf, st_nan, st_tiny, st_huge, st_inexact;
  logic [EXP_W-1:0] z_exp, a_exp, b_exp;
  logic [MAN_W-1:0] z_man;
  logic [13:0]      fail_vec;
  logic             bad_result;
  logic [3:0]       fail_code;

  assign st_zero    = status[0];
  assign st_inf     = status[1];
  assign st_nan     = status[2];
  assign st_tiny    = status[3];
  assign st_huge    = status[4];
  assign st_inexact = status[5];

  assign z_exp = z[DW-2 -: EXP_W];
  assign z_man = z[MAN_W-1:0];
  assign a_exp = a_al[DW-2 -: EXP_W];
  assign b_exp = b_al[DW-2 -: EXP_W];

  always_comb begin
    fail_vec     = '0;
    fail_vec[0]  = st_zero & st_inf;
    fail_vec[1]  = st_nan  & st_zero;
    fail_vec[2]  = st_nan  & st_inexact;
    fail_vec[3]  = st_nan  & st_huge;
    fail_vec[4]  = st_nan  & st_tiny;
    fail_vec[5]  = st_tiny & st_inf;
    fail_vec[6]  = st_huge & st_zero;
    fail_vec[7]  = st_huge & st_tiny;
    fail_vec[8]  = |status[7:6];
    fail_vec[9]  = st_zero & (z_exp != '0);
    fail_vec[10] = st_inf  & (z_exp != C_EXP_ONES);
    // A multiply produces a NaN from non-NaN inputs only for 0 x inf.
    fail_vec[11] = st_nan &
                   !(((a_exp == '0) && (b_exp == C_EXP_ONES)) ||
                     ((a_exp == C_EXP_ONES) && (b_exp == '0)));
    // "huge" means overflowed to inf or rounded to the largest finite value.
    fail_vec[12] = st_huge &
                   !((z_exp == C_EXP_ONES) ||
                     ((z_exp == C_EXP_ONES_M1) && (z_man == C_MAN_ONES)));
    // "tiny" means flushed to zero/denormal or rounded up to the smallest normal.
    fail_vec[13] = st_tiny &
                   !((z_exp == '0) ||
                     ((z_exp == C_EXP_ONE) && (z_man == '0)));
    if (!res_vld) begin
      fail_vec = '0;
    end
  end

  assign bad_result = |fail_vec;

  // Priority encoder: the lowest failing index wins.
  always_comb begin
    fail_code = 4'd0;
    for (int i = 13; i >= 0; i--) begin
      if (fail_vec[i]) begin
        fail_code = 4'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sticky state
  // --------------------------------------------------------------------------
  logic [13:0]      flags_q, flags_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       code_q, code_d;
  logic             fvld_q, fvld_d;
  logic             take_first;

  // A new first error is taken only when no error is held and clear is low.
  assign take_first = bad_result & ~fvld_q & ~clear;

  always_comb begin
    flags_d = flags_q | fail_vec;
    count_d = count_q;
    code_d  = code_q;
    fvld_d  = fvld_q;
    if (bad_result && (count_q != C_CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
    if (take_first) begin
      fvld_d = 1'b1;
      code_d = fail_code;
    end
    // Clear takes priority over a violation sampled in the same cycle.
    if (clear) begin
      flags_d = '0;
      count_d = '0;
      code_d  = '0;
      fvld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q <= '0;
      count_q <= '0;
      code_q  <= '0;
      fvld_q  <= 1'b0;
    end else begin
      flags_q <= flags_d;
      count_q <= count_d;
      code_q  <= code_d;
      fvld_q  <= fvld_d;
    end
  end

  assign err_flags      = flags_q;
  assign err_any        = |flags_q;
  assign err_count      = count_q;
  assign first_err_code = code_q;
  assign first_err_vld  = fvld_q;

`ifdef FP_MON_CAPTURE_EN
  logic [DW-1:0] cap_a_q, cap_a_d;
  logic [DW-1:0] cap_b_q, cap_b_d;
  logic [DW-1:0] cap_z_q, cap_z_d;
  logic [7:0]    cap_st_q, cap_st_d;

  always_comb begin
    cap_a_d  = cap_a_q;
    cap_b_d  = cap_b_q;
    cap_z_d  = cap_z_q;
    cap_st_d = cap_st_q;
    if (take_first) begin
      cap_a_d  = a_al;
      cap_b_d  = b_al;
      cap_z_d  = z;
      cap_st_d = status;
    end
    if (clear) begin
      cap_a_d  = '0;
      cap_b_d  = '0;
      cap_z_d  = '0;
      cap_st_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_a_q  <= '0;
      cap_b_q  <= '0;
      cap_z_q  <= '0;
      cap_st_q <= '0;
    end else begin
      cap_a_q  <= cap_a_d;
      cap_b_q  <= cap_b_d;
      cap_z_q  <= cap_z_d;
      cap_st_q <= cap_st_d;
    end
  end

  assign cap_a      = cap_a_q;
  assign cap_b      = cap_b_q;
  assign cap_z      = cap_z_q;
  assign cap_status = cap_st_q;
`else
  assign cap_a      = '0;
  assign cap_b      = '0;
  assign cap_z      = '0;
  assign cap_status = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_status_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_status_monitor
// Purpose  : Directed testbench for fp_status_monitor (FP32, LATENCY=2,
//            CNT_W=4). Each scenario task drives its stimulus and compares
//            the outputs against expected values that were worked out by hand.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_status_monitor;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int LATENCY = 2;
  localparam int CNT_W   = 4;
  localparam int DW      = 1 + EXP_W + MAN_W;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             valid_in = 1'b0;
  logic [DW-1:0]    a = '0;
  logic [DW-1:0]    b = '0;
  logic [DW-1:0]    z = '0;
  logic [7:0]       status = '0;
  logic             clear = 1'b0;
  logic [13:0]      err_flags;
  logic             err_any;
  logic [CNT_W-1:0] err_count;
  logic [3:0]       first_err_code;
  logic             first_err_vld;
  logic [DW-1:0]    cap_a, cap_b, cap_z;
  logic [7:0]       cap_status;

  int n_vec = 0;
  int n_err = 0;

  fp_status_monitor #(
    .EXP_W  (EXP_W),
    .MAN_W  (MAN_W),
    .LATENCY(LATENCY),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .a             (a),
    .b             (b),
    .z             (z),
    .status        (status),
    .clear         (clear),
    .err_flags     (err_flags),
    .err_any       (err_any),
    .err_count     (err_count),
    .first_err_code(first_err_code),
    .first_err_vld (first_err_vld),
    .cap_a         (cap_a),
    .cap_b         (cap_b),
    .cap_z         (cap_z),
    .cap_status    (cap_status)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, then return 1 time unit after the rising edge.
  task automatic drive(input logic v, input logic [DW-1:0] ia, input logic [DW-1:0] ib,
                       input logic [DW-1:0] iz, input logic [7:0] ist, input logic iclr);
    valid_in = v;
    a        = ia;
    b        = ib;
    z        = iz;
    status   = ist;
    clear    = iclr;
    @(posedge clk);
    #1;
  endtask

  // Issue one operation. The result is presented LATENCY cycles later.
  task automatic one_op(input logic [DW-1:0] ia, input logic [DW-1:0] ib,
                        input logic [DW-1:0] iz, input logic [7:0] ist);
    drive(1'b1, ia, ib, '0, 8'h00, 1'b0);
    drive(1'b0, '0, '0, '0, 8'h00, 1'b0);
    drive(1'b0, '0, '0, iz, ist, 1'b0);
  endtask

  task automatic do_clear();
    drive(1'b0, '0, '0, '0, 8'h00, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (err_flags !== 14'h0 || err_count !== 4'd0 || first_err_vld !== 1'b0 || err_any !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: flags=%h count=%0d fvld=%b any=%b, want 0/0/0/0",
               err_flags, err_count, first_err_vld, err_any);
    end
    rst = 1'b1;
    drive(1'b0, '0, '0, '0, 8'h00, 1'b0);
    n_vec++;
    if (err_flags !== 14'h0 || first_err_code !== 4'd0 || cap_z !== '0) begin
      n_err++;
      $display("FAIL after_release: flags=%h code=%0d capz=%h, want 0/0/0",
               err_flags, first_err_code, cap_z);
    end
  endtask

  task automatic test_legal_nan();
    one_op(32'h00000000, 32'h7F800000, 32'h7FC00000, 8'h04);
    n_vec++;
    if (err_flags !== 14'h0 || err_count !== 4'd0 || err_any !== 1'b0) begin
      n_err++;
      $display("FAIL legal_nan: flags=%h count=%0d any=%b, want 0/0/0", err_flags, err_count, err_any);
    end
  endtask

  task automatic test_zero_inf();
    one_op(32'h3F800000, 32'h3F800000, 32'h00000000, 8'h03);
    n_vec++;
    if (err_flags !== 14'h0401 || err_count !== 4'd1 || err_any !== 1'b1) begin
      n_err++;
      $display("FAIL zero_inf_flags: flags=%h count=%0d any=%b, want 0401/1/1",
               err_flags, err_count, err_any);
    end
    n_vec++;
    if (first_err_code !== 4'd0 || first_err_vld !== 1'b1) begin
      n_err++;
      $display("FAIL zero_inf_first: code=%0d vld=%b, want 0/1", first_err_code, first_err_vld);
    end
`ifdef FP_MON_CAPTURE_EN
    n_vec++;
    if (cap_a !== 32'h3F800000 || cap_b !== 32'h3F800000 || cap_z !== 32'h0 || cap_status !== 8'h03) begin
      n_err++;
      $display("FAIL capture: a=%h b=%h z=%h st=%h, want 3f800000/3f800000/0/03",
               cap_a, cap_b, cap_z, cap_status);
    end
`else
    n_vec++;
    if (cap_a !== '0 || cap_b !== '0 || cap_z !== '0 || cap_status !== 8'h00) begin
      n_err++;
      $display("FAIL capture_off: a=%h b=%h z=%h st=%h, want all 0", cap_a, cap_b, cap_z, cap_status);
    end
`endif
    do_clear();
    n_vec++;
    if (err_flags !== 14'h0 || err_count !== 4'd0 || first_err_vld !== 1'b0) begin
      n_err++;
      $display("FAIL clear: flags=%h count=%0d vld=%b, want 0/0/0", err_flags, err_count, first_err_vld);
    end
  endtask

  task automatic test_nan_operands();
    one_op(32'h3F800000, 32'h7F800000, 32'h7FC00000, 8'h04);
    n_vec++;
    if (err_flags !== 14'h0800 || first_err_code !== 4'd11 || err_count !== 4'd1) begin
      n_err++;
      $display("FAIL nan_operands: flags=%h code=%0d count=%0d, want 0800/11/1",
               err_flags, first_err_code, err_count);
    end
    do_clear();
  endtask

  task automatic test_huge_tiny();
    one_op(32'h7F000000, 32'h40000000, 32'h7F7FFFFF, 8'h10);
    n_vec++;
    if (err_flags !== 14'h0 || err_count !== 4'd0) begin
      n_err++;
      $display("FAIL huge_max_finite: flags=%h count=%0d, want 0/0", err_flags, err_count);
    end
    one_op(32'h7F000000, 32'h40000000, 32'h7F000000, 8'h10);
    n_vec++;
    if (err_flags !== 14'h1000 || err_count !== 4'd1 || first_err_code !== 4'd12) begin
      n_err++;
      $display("FAIL huge_bad: flags=%h count=%0d code=%0d, want 1000/1/12",
               err_flags, err_count, first_err_code);
    end
    do_clear();
    one_op(32'h00800000, 32'h3F000000, 32'h00800000, 8'h08);
    n_vec++;
    if (err_flags !== 14'h0 || err_count !== 4'd0) begin
      n_err++;
      $display("FAIL tiny_min_normal: flags=%h count=%0d, want 0/0", err_flags, err_count);
    end
    one_op(32'h00800000, 32'h3F000000, 32'h00800001, 8'h08);
    n_vec++;
    if (err_flags !== 14'h2000 || first_err_code !== 4'd13) begin
      n_err++;
      $display("FAIL tiny_bad: flags=%h code=%0d, want 2000/13", err_flags, first_err_code);
    end
    do_clear();
  endtask

  // 20 back-to-back results. The first is 0x03 (code 0) and the rest are rsv7 (code 8).
  task automatic test_back_to_back();
    for (int i = 0; i < 22; i++) begin
      drive((i < 20) ? 1'b1 : 1'b0, 32'h3F800000, 32'h3F800000, 32'h0,
            (i == 2) ? 8'h03 : 8'h80, 1'b0);
      if (i == 11) begin
        n_vec++;
        if (err_count !== 4'd10) begin
          n_err++;
          $display("FAIL count_mid: count=%0d, want 10", err_count);
        end
      end
    end
    n_vec++;
    if (err_count !== 4'd15) begin
      n_err++;
      $display("FAIL count_saturate: count=%0d, want 15", err_count);
    end
    n_vec++;
    if (err_flags !== 14'h0501 || first_err_code !== 4'd0 || first_err_vld !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_first: flags=%h code=%0d vld=%b, want 0501/0/1",
               err_flags, first_err_code, first_err_vld);
    end
    drive(1'b0, '0, '0, 32'h0, 8'h80, 1'b0);
    n_vec++;
    if (err_count !== 4'd15 || err_flags !== 14'h0501) begin
      n_err++;
      $display("FAIL hold_no_valid: count=%0d flags=%h, want 15/0501", err_count, err_flags);
    end
    do_clear();
  endtask

  task automatic test_clear_wins();
    drive(1'b1, 32'h0, 32'h0, '0, 8'h00, 1'b0);
    drive(1'b0, '0, '0, '0, 8'h00, 1'b0);
    drive(1'b0, '0, '0, 32'h0, 8'h03, 1'b1);
    n_vec++;
    if (err_flags !== 14'h0 || err_count !== 4'd0 || first_err_vld !== 1'b0 || err_any !== 1'b0) begin
      n_err++;
      $display("FAIL clear_wins: flags=%h count=%0d vld=%b any=%b, want 0/0/0/0",
               err_flags, err_count, first_err_vld, err_any);
    end
  endtask

  task automatic test_reset_midstream();
    one_op(32'h0, 32'h0, 32'h0, 8'h40);
    n_vec++;
    if (err_flags !== 14'h0100 || first_err_code !== 4'd8) begin
      n_err++;
      $display("FAIL pre_reset: flags=%h code=%0d, want 0100/8", err_flags, first_err_code);
    end
    drive(1'b1, 32'h0, 32'h0, '0, 8'h00, 1'b0);
    valid_in = 1'b0;
    #1 rst = 1'b0;
    #1;
    n_vec++;
    if (err_flags !== 14'h0 || err_count !== 4'd0 || first_err_vld !== 1'b0 || err_any !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: flags=%h count=%0d vld=%b any=%b, want 0/0/0/0",
               err_flags, err_count, first_err_vld, err_any);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    drive(1'b0, '0, '0, 32'h0, 8'h03, 1'b0);
    drive(1'b0, '0, '0, 32'h0, 8'h03, 1'b0);
    n_vec++;
    if (err_flags !== 14'h0 || err_count !== 4'd0) begin
      n_err++;
      $display("FAIL inflight_dropped: flags=%h count=%0d, want 0/0", err_flags, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_legal_nan();
    test_zero_inf();
    test_nan_operands();
    test_huge_tiny();
    test_back_to_back();
    test_clear_wins();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
